// File: rtl/div_if.sv
// Divider request/response bundle: operands and controls toward the core,
// status and {remainder, quotient} result back to the requester.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               cancel;
  logic               sign_en;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic [2*WIDTH-1:0] out;

  modport master (
    output start, cancel, sign_en, op1, op2,
    input  busy, done, div_zero, out
  );

  modport slave (
    input  start, cancel, sign_en, op1, op2,
    output busy, done, div_zero, out
  );
endinterface

// File: rtl/div_core.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, result {remainder, quotient}.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   rem_reg, quo_reg, divisor_reg, dividend_raw_reg;
  logic               sign_q_reg, sign_r_reg, zero_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] out_reg;
  logic               done_reg, div_zero_reg;

  logic               accept;
  logic               neg1, neg2;
  logic [WIDTH-1:0]   abs_op1, abs_op2;
  logic [WIDTH:0]     shifted;
  logic               trial_ok;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic [WIDTH-1:0]   rem_fix, quo_fix;
  logic [2*WIDTH-1:0] result;

  assign accept  = bus.start & ~bus.cancel;
  assign neg1    = bus.sign_en & bus.op1[WIDTH-1];
  assign neg2    = bus.sign_en & bus.op2[WIDTH-1];
  assign abs_op1 = neg1 ? -bus.op1 : bus.op1;
  assign abs_op2 = neg2 ? -bus.op2 : bus.op2;

  // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1
  // bits and a successful trial subtraction always fits back into WIDTH bits.
  assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
  assign trial_ok = (shifted >= {1'b0, divisor_reg});
  assign rem_step = trial_ok ? (shifted[WIDTH-1:0] - divisor_reg) : shifted[WIDTH-1:0];
  assign quo_step = {quo_reg[WIDTH-2:0], trial_ok};

  assign quo_fix = sign_q_reg ? -quo_reg : quo_reg;
  assign rem_fix = sign_r_reg ? -rem_reg : rem_reg;
  assign result  = zero_reg ? {dividend_raw_reg, {WIDTH{1'b1}}} : {rem_fix, quo_fix};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_next = (bus.op2 == '0) ? FIX : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        if (bus.cancel)                       state_next = IDLE;
        else if (cnt_reg == CW'(WIDTH - 1))   state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg          <= '0;
      quo_reg          <= '0;
      divisor_reg      <= '0;
      dividend_raw_reg <= '0;
      sign_q_reg       <= 1'b0;
      sign_r_reg       <= 1'b0;
      zero_reg         <= 1'b0;
      cnt_reg          <= '0;
      out_reg          <= '0;
      done_reg         <= 1'b0;
      div_zero_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rem_reg          <= '0;
            quo_reg          <= abs_op1;
            divisor_reg      <= abs_op2;
            dividend_raw_reg <= bus.op1;
            sign_q_reg       <= neg1 ^ neg2;
            sign_r_reg       <= neg1;
            zero_reg         <= (bus.op2 == '0);
            cnt_reg          <= '0;
          end
        end
        CALC: begin
          if (!bus.cancel) begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        FIX: begin
          // A flush here drops the result; the previous one stays visible.
          if (!bus.cancel) begin
            out_reg      <= result;
            done_reg     <= 1'b1;
            div_zero_reg <= zero_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_reg == CALC) || (state_reg == FIX);
  assign bus.done     = done_reg;
  assign bus.out      = out_reg;
  assign bus.div_zero = div_zero_reg;
endmodule

// File: tb/tb_div_core.sv
// Scoreboard bench for div_core: expected results queued at issue, compared on done.
module tb_div_core;
  localparam int WIDTH = 32;

  typedef struct {
    logic [63:0] out;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  logic [63:0] last_out = '0;
  logic        last_dz = 1'b0;

  div_if #(.WIDTH(WIDTH)) bus();
  div_core #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa, sd;
    logic [31:0] q, r;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = $signed(a);
      sd = $signed(b);
      q = sa / sd;
      r = sa % sd;
    end
    return {1'b0, r, q};
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        $display("[TB] done cyc=%0d out=%h div_zero=%b", cyc, bus.out, bus.div_zero);
        check("out", bus.out, e.out);
        check("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
        check("latency", 64'(cyc), 64'(e.cyc));
        last_out = e.out;
        last_dz  = e.dz;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
    exp_t e;
    logic [64:0] m;
    int lat;
    bus.op1 = a;
    bus.op2 = b;
    bus.sign_en = s;
    bus.start = 1'b1;
    if (push) begin
      m = model(a, b, s);
      lat = WIDTH + 1;
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) lat = 1;
`endif
      e.out = m[63:0];
      e.dz  = m[64];
      e.cyc = cyc + 1 + lat;
      sbq.push_back(e);
      $display("[TB] issue op1=%h op2=%h signed=%b", a, b, s);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      check("timeout", 64'd1, 64'd0);
      sbq.delete();
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    #1 issue(a, b, s, 1'b1);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    bus.sign_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_out", bus.out, 64'd0);
    check("rst_dz", {63'd0, bus.div_zero}, 64'd0);
    #1 rst = 1'b0;

    // 100/7 with a full busy/done profile
    @(negedge clk);
    #1 issue(32'd100, 32'd7, 1'b0, 1'b1);
    bad = 0;
    for (int k = 0; k <= WIDTH + 1; k++) begin
      @(negedge clk);
      #1;
      if (bus.busy !== (k <= WIDTH)) bad++;
    end
    check("busy_profile", 64'(bad), 64'd0);
    wait_done();

    run(32'hFFFF_FFF9, 32'd2, 1'b1);
    run(32'd7, 32'hFFFF_FFFE, 1'b1);
    run(32'hFFFF_FFF9, 32'd2, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run(32'hFFFF_FFFF, 32'd1, 1'b0);
    run(32'h1234_5678, 32'd0, 1'b0);
    run(32'h1234_5678, 32'd0, 1'b1);
    run(32'h8000_0000, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++)
      run($urandom, (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom, 1'(i % 3 == 0));

    // Back-to-back: new start in the done cycle
    run(32'd1000, 32'd3, 1'b0);
    issue(32'hFFFF_FC18, 32'd3, 1'b1, 1'b1);
    wait_done();
    issue(32'd55, 32'd0, 1'b0, 1'b1);
    wait_done();

    // Cancel at 10th CALC cycle; start+cancel held into IDLE is dropped
    @(negedge clk);
    #1 issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    bus.cancel = 1'b1;
    bus.start = 1'b1;
    bus.op1 = 32'd5;
    bus.op2 = 32'd1;
    @(negedge clk);
    check("cancel_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    check("cancel_start_busy", {63'd0, bus.busy}, 64'd0);
    #1;
    bus.cancel = 1'b0;
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    check("cancel_hold_out", bus.out, last_out);
    check("cancel_hold_dz", {63'd0, bus.div_zero}, {63'd0, last_dz});
    run(32'd100, 32'd7, 1'b0);

    // Re-pulsed start mid-CALC is ignored
    @(negedge clk);
    #1 issue(32'd100, 32'd7, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    bus.start = 1'b1;
    bus.op1 = 32'd999;
    bus.op2 = 32'd4;
    bus.sign_en = 1'b1;
    @(negedge clk);
    #1 bus.start = 1'b0;
    wait_done();

    // Reset mid-CALC clears outputs without a done
    @(negedge clk);
    #1 issue(32'd12345, 32'd17, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_done", {63'd0, bus.done}, 64'd0);
    check("midrst_out", bus.out, 64'd0);
    check("midrst_dz", {63'd0, bus.div_zero}, 64'd0);
    #1 rst = 1'b0;
    last_out = '0;
    last_dz = 1'b0;
    repeat (40) @(negedge clk);
    run(32'hFFFF_FF9C, 32'd7, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_core.md
Name: div_core

Overview:
- Iterative radix-2 restoring integer divider; the inverse datapath to the Booth/Wallace multiplier in the EX stage.
- Accepts a dividend/divisor pair on a start pulse and runs one quotient bit per cycle.
- Returns {remainder, quotient} on the same 64-bit {HI,LO} result layout as the multiplier.
- Supports signed (DIV) and unsigned (DIVU) operation; the pipeline stalls on busy and flushes via cancel.

Parameters:
WIDTH, 32, operand width; quotient and remainder are each WIDTH bits, iteration count is WIDTH

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only when state is IDLE and cancel=0
op1  input  WIDTH  dividend, sampled on accepting edge
op2  input  WIDTH  divisor, sampled on accepting edge
sign_en  input  1  1 = signed (two's complement), 0 = unsigned; sampled with operands
cancel  input  1  pipeline flush; aborts any operation in progress
busy  output  1  high in CALC and FIX states
done  output  1  one-cycle pulse; out and div_zero valid from this cycle
out  output  2*WIDTH  {remainder, quotient}; held until next done
div_zero  output  1  divisor was zero for the result currently on out

Behaviour:
- Reset values (rst sampled high at an edge): state IDLE, busy=0, done=0, out=0, div_zero=0, iteration counter=0. Reset overrides start and cancel and aborts a run with no done.
- States:
  - IDLE: on start & !cancel, latch |op1|, |op2| (absolute values when sign_en, else raw), sign_q=op1[W-1]^op2[W-1], sign_r=op1[W-1] (both forced 0 when !sign_en), zero flag=(op2==0). Go to CALC, counter=0.
  - CALC: per edge, partial remainder {R,Q} shifts left 1; trial = R - divisor (WIDTH+1 bits). If non-negative, R=trial and Q[0]=1; else restore and Q[0]=0. counter++. After counter reaches WIDTH-1 the edge moves to FIX (exactly WIDTH iterations).
  - FIX: quotient negated if sign_q, remainder negated if sign_r. Register out, assert done for this one cycle, set div_zero=zero flag, return to IDLE.
- Latency: with start accepted at the end of cycle c, done is high during cycle c+WIDTH+2 (c+34 for WIDTH=32). busy is high during cycles c+1..c+WIDTH+1.
- Signed results truncate toward zero; the remainder takes the sign of the dividend.
- Overflow 0x8000_0000 / -1 (signed) yields quotient 0x8000_0000 and remainder 0 by two's-complement wrap, with no flag.
- Divide by zero (either mode): result forced to quotient={WIDTH{1}}, remainder=op1 (original, unconverted); div_zero=1.
- start while busy is ignored; operands are not re-sampled.
- cancel in CALC or FIX: next edge goes to IDLE, no done pulse, out and div_zero keep their previous values.
- cancel together with start in IDLE: cancel wins and nothing is accepted.
- start may be asserted in the cycle done is high (state is IDLE); it is accepted.
- done never asserts for two consecutive cycles.

Optional Feature:
DIV_ZERO_FAST_EN
- Defined: divisor zero detected in IDLE skips CALC. Go directly to FIX, so done is high during cycle c+2 with the forced divide-by-zero result.
- Undefined: divide by zero takes the full WIDTH+2 latency with the same forced result and flag.
- All non-zero-divisor behaviour is identical in both builds.

Test Plan:
- Unsigned 100 / 7, start at cycle c -> busy high c+1..c+33; done only in c+34; out={32'd2, 32'd14}; div_zero=0.
- Signed -7 / 2 (0xFFFF_FFF9 / 0x2) -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. Signed 7 / -2 -> quotient 0xFFFF_FFFD, remainder 0x1. Unsigned 0xFFFF_FFF9 / 2 -> quotient 0x7FFF_FFFC, remainder 1.
- Signed 0x8000_0000 / 0xFFFF_FFFF -> out={32'h0, 32'h8000_0000}, div_zero=0. Unsigned 0xFFFF_FFFF / 1 -> quotient 0xFFFF_FFFF, remainder 0.
- Divide by zero, op1=0x1234_5678 -> out={32'h1234_5678, 32'hFFFF_FFFF}, div_zero=1. done at c+34 without DIV_ZERO_FAST_EN; at c+2 with it.
- cancel at 10th CALC cycle -> busy low next cycle, no done. A start in the same cycle as cancel is dropped. A fresh 100/7 started afterwards completes normally, and out holds the prior result until then.
- start re-pulsed with different operands mid-CALC -> ignored, and the original result is returned. rst asserted mid-CALC -> all outputs 0 next cycle, no done.
